// File: rtl/fifo_param.sv
// -----------------------------------------------------------------------------
// fifo_param
// Parametrised single-clock FIFO with arbitrary (non power-of-two) depth,
// programmable almost-full / almost-empty flags, occupancy count, one-cycle
// overflow / underflow error pulses and a selectable read mode.
//
// Parameters
//   WIDTH          data width in bits (>= 1)
//   DEPTH          number of entries (>= 2, any integer)
//   AFULL_THRESH   almost_full  when count >= AFULL_THRESH  (1..DEPTH)
//   AEMPTY_THRESH  almost_empty when count <= AEMPTY_THRESH (0..DEPTH-1)
//   FWFT           1: show-ahead, head word visible on rd_data
//                  0: registered read, word appears one cycle after the pop
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   wr_en/wr_data push request and data
//   rd_en         pop request
//   rd_data       read data
//   rd_valid      FWFT=1: !empty; FWFT=0: one-cycle pulse after an accepted pop
//   full/empty    count == DEPTH / count == 0
//   almost_full   count >= AFULL_THRESH
//   almost_empty  count <= AEMPTY_THRESH
//   count         current occupancy
//   overflow      one-cycle pulse: a push was rejected because the FIFO was full
//   underflow     one-cycle pulse: a pop was rejected because the FIFO was empty
// -----------------------------------------------------------------------------
module fifo_param #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 4,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1,
    parameter bit FWFT          = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AFULL = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] CNT_AEMPT = CW'(AEMPTY_THRESH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_almost_full;
    logic             r_almost_empty;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_next;

    // Explicit wrap at DEPTH-1 so non power-of-two depths never index past
    // the last entry.
    function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    endfunction

    // Accept decisions use only registered state, so a full FIFO can still
    // pop and an empty FIFO can still push in the same cycle.
    assign w_push       = wr_en && !r_full;
    assign w_pop        = rd_en && !r_empty;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= f_next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_next_ptr(r_rd_ptr);
            // All flags derive from the same next count so they never
            // disagree with count in any cycle.
            r_count        <= w_count_next;
            r_full         <= (w_count_next == CNT_FULL);
            r_empty        <= (w_count_next == '0);
            r_almost_full  <= (w_count_next >= CNT_AFULL);
            r_almost_empty <= (w_count_next <= CNT_AEMPT);
            r_overflow     <= wr_en && r_full;
            r_underflow    <= rd_en && r_empty;
        end
    end

    // NOTE: the storage array is deliberately not reset; only the pointers
    // and count define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (!rst && w_push) r_mem[r_wr_ptr] <= wr_data;
    end

    generate
        if (FWFT) begin : g_show_ahead
            // Head word is visible combinationally; a pop consumes it.
            assign rd_data  = r_mem[r_rd_ptr];
            assign rd_valid = !r_empty;
        end else begin : g_registered
            logic [WIDTH-1:0] r_rd_data;
            logic             r_rd_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_pop;
                    if (w_pop) r_rd_data <= r_mem[r_rd_ptr];
                end
            end

            assign rd_data  = r_rd_data;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_param
// Directed bench for fifo_param. Three instances share clk/rst:
//   u_a : WIDTH 8, DEPTH 4, FWFT 1 (flags, overflow/underflow, reset)
//   u_b : WIDTH 8, DEPTH 5, FWFT 1 (non power-of-two pointer wrap)
//   u_c : WIDTH 8, DEPTH 4, FWFT 0 (registered read timing)
// Each accepted push queues its expected read word; a per-instance monitor
// pops and compares whenever the instance presents a word.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- instance A ----------------
    logic       a_wr = 1'b0, a_rd = 1'b0;
    logic [7:0] a_wd = '0, a_rdata;
    logic       a_valid, a_full, a_empty, a_af, a_ae, a_ov, a_un;
    logic [2:0] a_cnt;
    logic [7:0] a_q [$];

    fifo_param #(.WIDTH(8), .DEPTH(4), .FWFT(1'b1)) u_a (
        .clk(clk), .rst(rst), .wr_en(a_wr), .wr_data(a_wd), .rd_en(a_rd),
        .rd_data(a_rdata), .rd_valid(a_valid), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt),
        .overflow(a_ov), .underflow(a_un)
    );

    // ---------------- instance B ----------------
    logic       b_wr = 1'b0, b_rd = 1'b0;
    logic [7:0] b_wd = '0, b_rdata;
    logic       b_valid, b_full, b_empty, b_af, b_ae, b_ov, b_un;
    logic [2:0] b_cnt;
    logic [7:0] b_q [$];

    fifo_param #(.WIDTH(8), .DEPTH(5), .FWFT(1'b1)) u_b (
        .clk(clk), .rst(rst), .wr_en(b_wr), .wr_data(b_wd), .rd_en(b_rd),
        .rd_data(b_rdata), .rd_valid(b_valid), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt),
        .overflow(b_ov), .underflow(b_un)
    );

    // ---------------- instance C ----------------
    logic       c_wr = 1'b0, c_rd = 1'b0;
    logic [7:0] c_wd = '0, c_rdata;
    logic       c_valid, c_full, c_empty, c_af, c_ae, c_ov, c_un;
    logic [2:0] c_cnt;
    logic [7:0] c_q [$];

    fifo_param #(.WIDTH(8), .DEPTH(4), .FWFT(1'b0)) u_c (
        .clk(clk), .rst(rst), .wr_en(c_wr), .wr_data(c_wd), .rd_en(c_rd),
        .rd_data(c_rdata), .rd_valid(c_valid), .full(c_full), .empty(c_empty),
        .almost_full(c_af), .almost_empty(c_ae), .count(c_cnt),
        .overflow(c_ov), .underflow(c_un)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 ns after
    // the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitors (sample on the falling edge) ----------------
    logic [7:0] a_exp, b_exp, c_exp;

    always @(negedge clk) begin
        if (!rst && a_rd && a_valid) begin
            if (a_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL a_unexpected_word: got %0h, expected none", a_rdata);
            end else begin
                a_exp = a_q.pop_front();
                check("a_rd_data", a_rdata, a_exp);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_rd && b_valid) begin
            if (b_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL b_unexpected_word: got %0h, expected none", b_rdata);
            end else begin
                b_exp = b_q.pop_front();
                check("b_rd_data", b_rdata, b_exp);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && c_valid) begin
            if (c_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL c_unexpected_word: got %0h, expected none", c_rdata);
            end else begin
                c_exp = c_q.pop_front();
                check("c_rd_data", c_rdata, c_exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] fill_vals [4];

    initial begin
        fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44};

        // Reset state
        rst = 1'b1;
        step(); step();
        check("rst_count",     a_cnt,   0);
        check("rst_empty",     a_empty, 1);
        check("rst_full",      a_full,  0);
        check("rst_aempty",    a_ae,    1);
        check("rst_afull",     a_af,    0);
        check("rst_overflow",  a_ov,    0);
        check("rst_underflow", a_un,    0);
        check("rst_valid",     a_valid, 0);
        check("rst_c_valid",   c_valid, 0);
        check("rst_c_rdata",   c_rdata, 0);
        rst = 1'b0;

        // Fill A: count 1..4, almost_full from 3, full at 4
        for (int i = 0; i < 4; i++) begin
            a_wr = 1'b1; a_wd = fill_vals[i]; a_q.push_back(fill_vals[i]);
            step();
            check("fill_count",  a_cnt,   i + 1);
            check("fill_empty",  a_empty, 0);
            check("fill_afull",  a_af,    (i + 1 >= 3) ? 1 : 0);
            check("fill_full",   a_full,  (i == 3) ? 1 : 0);
            check("fill_aempty", a_ae,    (i == 0) ? 1 : 0);
        end

        // Push while full: rejected, one-cycle overflow pulse
        a_wd = 8'h55;
        step();
        a_wr = 1'b0;
        check("ovf_pulse", a_ov,   1);
        check("ovf_count", a_cnt,  4);
        check("ovf_full",  a_full, 1);
        step();
        check("ovf_clear", a_ov,   0);

        // Drain: 0x11..0x44 in order (monitor), empty after last
        a_rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_count", a_cnt, 3 - i);
        end
        a_rd = 1'b0;
        check("drain_empty", a_empty, 1);
        check("drain_ae",    a_ae,    1);

        // Pop while empty: underflow pulse, count stays 0
        a_rd = 1'b1;
        step();
        a_rd = 1'b0;
        check("unf_pulse", a_un,  1);
        check("unf_count", a_cnt, 0);
        step();
        check("unf_clear", a_un,  0);

        // Empty with push+pop: push accepted, pop rejected
        a_wr = 1'b1; a_rd = 1'b1; a_wd = 8'hA5; a_q.push_back(8'hA5);
        step();
        a_wr = 1'b0; a_rd = 1'b0;
        check("ewr_count", a_cnt,   1);
        check("ewr_unf",   a_un,    1);
        check("ewr_empty", a_empty, 0);
        a_rd = 1'b1;
        step();
        a_rd = 1'b0;
        check("ewr_pop_count", a_cnt, 0);

        // Full with push+pop: pop accepted, push rejected
        for (int i = 0; i < 4; i++) begin
            a_wr = 1'b1; a_wd = 8'h01 + 8'(i); a_q.push_back(8'h01 + 8'(i));
            step();
        end
        a_wr = 1'b1; a_rd = 1'b1; a_wd = 8'h99;
        step();
        a_wr = 1'b0; a_rd = 1'b0;
        check("fwr_ovf",   a_ov,   1);
        check("fwr_count", a_cnt,  3);
        check("fwr_full",  a_full, 0);
        a_rd = 1'b1;
        step(); step(); step();
        a_rd = 1'b0;
        check("fwr_empty", a_empty, 1);

        // DEPTH=5: hold count at 2 while pointers wrap several times
        for (int i = 0; i < 2; i++) begin
            b_wr = 1'b1; b_wd = 8'hB0 + 8'(i); b_q.push_back(8'hB0 + 8'(i));
            step();
        end
        check("b_pre_count", b_cnt, 2);
        b_rd = 1'b1;
        for (int i = 0; i < 20; i++) begin
            b_wd = 8'h10 + 8'(i); b_q.push_back(8'h10 + 8'(i));
            step();
            check("b_steady_count", b_cnt, 2);
        end
        b_wr = 1'b0;
        step(); step();
        b_rd = 1'b0;
        check("b_empty", b_empty, 1);

        // FWFT=0: word appears only the cycle after the pop, then holds
        c_wr = 1'b1; c_wd = 8'h3C; c_q.push_back(8'h3C);
        step();
        c_wr = 1'b0;
        check("c_no_valid_yet", c_valid, 0);
        check("c_no_showahead", c_rdata, 0);
        c_rd = 1'b1;
        step();
        c_rd = 1'b0;
        check("c_valid_n1", c_valid, 1);
        check("c_data_n1",  c_rdata, 8'h3C);
        step();
        check("c_valid_n2", c_valid, 0);
        check("c_data_hold", c_rdata, 8'h3C);

        // Reset mid-operation with a push in the reset cycle
        for (int i = 0; i < 3; i++) begin
            a_wr = 1'b1; a_wd = 8'hD0 + 8'(i);
            step();
        end
        check("prerst_count", a_cnt, 3);
        rst = 1'b1; a_wd = 8'hEE;
        step();
        rst = 1'b0; a_wr = 1'b0;
        check("mrst_count", a_cnt,   0);
        check("mrst_empty", a_empty, 1);
        check("mrst_ovf",   a_ov,    0);
        a_wr = 1'b1; a_wd = 8'h77; a_q.push_back(8'h77);
        step();
        a_wr = 1'b0;
        check("mrst_push_count", a_cnt, 1);
        a_rd = 1'b1;
        step();
        a_rd = 1'b0;
        check("mrst_pop_empty", a_empty, 1);

        step(); step();
        check("a_q_drained", a_q.size(), 0);
        check("b_q_drained", b_q.size(), 0);
        check("c_q_drained", c_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
